// File: rtl/me_match_pkg.sv
// Shared types and constants for the me_match search scheduler.
package me_match_pkg;

  localparam int MV_W_DFLT  = 5;
  localparam int SAD_W_DFLT = 16;

  localparam logic [SAD_W_DFLT-1:0] SAD_MAX = '1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_e;

endpackage

// File: rtl/me_best_tracker.sv
// Offset FIFO that pairs returning SADs with their candidates and keeps the
// running minimum (strict less-than, so the first minimum in raster order wins).
module me_best_tracker
  import me_match_pkg::*;
#(
  parameter int MV_W  = MV_W_DFLT,
  parameter int SAD_W = SAD_W_DFLT,
  parameter int DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    push,
  input  logic signed [MV_W-1:0]  push_dx,
  input  logic signed [MV_W-1:0]  push_dy,
  input  logic                    pop,
  input  logic [SAD_W-1:0]        sad_value,
  output logic signed [MV_W-1:0]  best_dx,
  output logic signed [MV_W-1:0]  best_dy,
  output logic [SAD_W-1:0]        best_sad
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [2*MV_W-1:0]      fifo_mem [DEPTH];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic signed [MV_W-1:0] head_dx;
  logic signed [MV_W-1:0] head_dy;

  // The scheduler never pushes into a full FIFO nor pops an empty one.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign {head_dx, head_dy} = fifo_mem[rd_ptr];

  // NOTE: storage has no reset; the pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {push_dx, push_dy};
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      best_dx  <= '0;
      best_dy  <= '0;
      best_sad <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (clear) begin
        best_sad <= SAD_W'(SAD_MAX);
      end else if (pop && (sad_value < best_sad)) begin
        best_sad <= sad_value;
        best_dx  <= head_dx;
        best_dy  <= head_dy;
      end
    end
  end

endmodule

// File: rtl/me_search_sched.sv
// Search-window scheduler: raster-walks (2R+1)^2 offsets to the SAD datapath and
// reports the best vector. Optional early termination under `ME_EARLY_TERM_EN.
module me_search_sched
  import me_match_pkg::*;
#(
  parameter int MAX_RANGE       = 8,
  parameter int MV_W            = MV_W_DFLT,
  parameter int SAD_W           = SAD_W_DFLT,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                    s00_axi_aclk,
  input  logic                    s00_axi_aresetn,
  input  logic                    start,
  input  logic [MV_W-1:0]         cfg_range,
  input  logic [SAD_W-1:0]        cfg_thresh,
  output logic                    cand_valid,
  input  logic                    cand_ready,
  output logic signed [MV_W-1:0]  cand_dx,
  output logic signed [MV_W-1:0]  cand_dy,
  input  logic                    sad_valid,
  input  logic [SAD_W-1:0]        sad_value,
  output logic                    busy,
  output logic                    done,
  output logic signed [MV_W-1:0]  best_dx,
  output logic signed [MV_W-1:0]  best_dy,
  output logic [SAD_W-1:0]        best_sad
);

  localparam int              OW        = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [MV_W-1:0] RANGE_CAP = MV_W'(MAX_RANGE);

  state_e                 state_q, state_d;
  logic [MV_W-1:0]        range_q;
  logic [MV_W-1:0]        start_range;
  logic signed [MV_W-1:0] r_start;
  logic signed [MV_W-1:0] r_pos;
  logic [OW-1:0]          outst_q;
  logic                   accept;
  logic                   hs;
  logic                   pop;
  logic                   last_cand;
  logic                   early_stop;

  assign accept      = (state_q == IDLE) && start;
  assign start_range = (cfg_range > RANGE_CAP) ? RANGE_CAP : cfg_range;
  assign r_start     = $signed(start_range);
  assign r_pos       = $signed(range_q);
  assign hs          = cand_valid & cand_ready;
  // Returns with nothing outstanding (e.g. stragglers after a reset) are dropped.
  assign pop         = sad_valid & (outst_q != '0);
  assign last_cand   = (cand_dx == r_pos) && (cand_dy == r_pos);

`ifdef ME_EARLY_TERM_EN
  logic [SAD_W-1:0] thresh_q;

  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) thresh_q <= '0;
    else if (accept)      thresh_q <= cfg_thresh;
  end

  assign early_stop = pop && (sad_value < thresh_q) && (state_q == ISSUE);
`else
  logic unused_thresh;
  assign unused_thresh = ^cfg_thresh;
  assign early_stop    = 1'b0;
`endif

  // NOTE: every output of this block gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    cand_valid = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_q)
      IDLE: if (start) state_d = ISSUE;
      ISSUE: begin
        busy       = 1'b1;
        cand_valid = (outst_q != OW'(MAX_OUTSTANDING));
        if ((hs && last_cand) || early_stop) state_d = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (outst_q == '0) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) begin
      state_q <= IDLE;
      range_q <= '0;
      outst_q <= '0;
      cand_dx <= '0;
      cand_dy <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        range_q <= start_range;
        cand_dx <= -r_start;
        cand_dy <= -r_start;
      end else if (hs && !last_cand) begin
        // dx is the inner loop; wrapping it steps dy.
        if (cand_dx == r_pos) begin
          cand_dx <= -r_pos;
          cand_dy <= cand_dy + MV_W'(1);
        end else begin
          cand_dx <= cand_dx + MV_W'(1);
        end
      end
      if (hs && !pop)      outst_q <= outst_q + OW'(1);
      else if (!hs && pop) outst_q <= outst_q - OW'(1);
    end
  end

  me_best_tracker #(
    .MV_W  (MV_W),
    .SAD_W (SAD_W),
    .DEPTH (MAX_OUTSTANDING)
  ) u_best (
    .clk       (s00_axi_aclk),
    .rst_n     (s00_axi_aresetn),
    .clear     (accept),
    .push      (hs),
    .push_dx   (cand_dx),
    .push_dy   (cand_dy),
    .pop       (pop),
    .sad_value (sad_value),
    .best_dx   (best_dx),
    .best_dy   (best_dy),
    .best_sad  (best_sad)
  );

endmodule

// File: tb/tb_me_search_sched.sv
// Directed + randomized bench for me_search_sched with a queue-based datapath
// model and a window/minimum reference computed from the search rules.
module tb_me_search_sched;

  localparam int MAX_RANGE = 8;
  localparam int MV_W      = 5;
  localparam int SAD_W     = 16;
  localparam int MAX_OUT   = 8;

  logic                   tb_ACLK = 1'b0;
  logic                   tb_ARESETN;
  logic                   start;
  logic [MV_W-1:0]        cfg_range;
  logic [SAD_W-1:0]       cfg_thresh;
  logic                   cand_valid;
  logic                   cand_ready;
  logic signed [MV_W-1:0] cand_dx;
  logic signed [MV_W-1:0] cand_dy;
  logic                   sad_valid;
  logic [SAD_W-1:0]       sad_value;
  logic                   busy;
  logic                   done;
  logic signed [MV_W-1:0] best_dx;
  logic signed [MV_W-1:0] best_dy;
  logic [SAD_W-1:0]       best_sad;

  me_search_sched dut (
    .s00_axi_aclk    (tb_ACLK),
    .s00_axi_aresetn (tb_ARESETN),
    .start           (start),
    .cfg_range       (cfg_range),
    .cfg_thresh      (cfg_thresh),
    .cand_valid      (cand_valid),
    .cand_ready      (cand_ready),
    .cand_dx         (cand_dx),
    .cand_dy         (cand_dy),
    .sad_valid       (sad_valid),
    .sad_value       (sad_value),
    .busy            (busy),
    .done            (done),
    .best_dx         (best_dx),
    .best_dy         (best_dy),
    .best_sad        (best_sad)
  );

  always #5 tb_ACLK = ~tb_ACLK;

  typedef struct { int dx; int dy; int sad; } cand_t;
  typedef struct { int sad; int due; } resp_t;

  int    vectors     = 0;
  int    miscompares = 0;
  cand_t exp_q[$];
  cand_t iss_q[$];
  resp_t pend_q[$];
  int    cyc = 0, n_out = 0, stale_cnt = 0, sad_mode = 0, lat = 3;
  int    first_hs_cyc = 0, last_hs_cyc = 0;
  bit    rand_ready = 1'b0, inject = 1'b0, stall_prev = 1'b0;
  logic signed [MV_W-1:0] prev_dx, prev_dy;
  cand_t bfm_c;
  resp_t bfm_r;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, $signed(observed), $signed(expected));
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // SAD the modelled datapath returns for an offset, per scenario.
  function automatic int sad_of(input int dx, input int dy);
    case (sad_mode)
      0:       return iabs(dx) + iabs(dy) + 5;
      1:       return ((dx == 1 && dy == -2) || (dx == 2 && dy == 2)) ? 7 : 100;
      2:       return int'($urandom_range(0, 2000));
      3:       return (dx == -1 && dy == -3) ? 4 : 50;
      default: return 33;
    endcase
  endfunction

  // Datapath model: accepts candidates, returns SADs in order after `lat` cycles.
  initial begin
    forever begin
      @(negedge tb_ACLK);
      cyc++;
      if (tb_ARESETN !== 1'b1) begin
        cand_ready = 1'b0;
        sad_valid  = 1'b0;
        stall_prev = 1'b0;
      end else begin
        if (stall_prev && cand_valid === 1'b1) begin
          check("stall_dx", cand_dx, prev_dx);
          check("stall_dy", cand_dy, prev_dy);
        end
        cand_ready = rand_ready ? ($urandom_range(0, 99) < 30) : 1'b1;
        if (cand_valid === 1'b1 && cand_ready) begin
          bfm_c.dx = cand_dx;
          bfm_c.dy = cand_dy;
          if (iss_q.size() < exp_q.size()) begin
            check("raster_dx", cand_dx, exp_q[iss_q.size()].dx);
            check("raster_dy", cand_dy, exp_q[iss_q.size()].dy);
          end else begin
            check("cand_count_overrun", iss_q.size() + 1, exp_q.size());
          end
          bfm_c.sad = sad_of(bfm_c.dx, bfm_c.dy);
          iss_q.push_back(bfm_c);
          pend_q.push_back('{bfm_c.sad, cyc + lat});
          if (iss_q.size() == 1) first_hs_cyc = cyc;
          last_hs_cyc = cyc;
          n_out++;
          check("outstanding_le_max", n_out <= MAX_OUT, 1);
        end
        stall_prev = (cand_valid === 1'b1) && !cand_ready;
        prev_dx    = cand_dx;
        prev_dy    = cand_dy;
        if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
          bfm_r     = pend_q.pop_front();
          sad_valid = 1'b1;
          sad_value = SAD_W'(bfm_r.sad);
          if (stale_cnt > 0) stale_cnt--;
          else               n_out--;
        end else if (inject) begin
          sad_valid = 1'b1;
          sad_value = '0;
          inject    = 1'b0;
        end else begin
          sad_valid = 1'b0;
          sad_value = SAD_W'($urandom);
        end
      end
    end
  end

  task automatic step();
    @(negedge tb_ACLK);
    #1;
  endtask

  task automatic load_window(input int range);
    int r;
    r = (range > MAX_RANGE) ? MAX_RANGE : range;
    exp_q.delete();
    iss_q.delete();
    for (int dy = -r; dy <= r; dy++)
      for (int dx = -r; dx <= r; dx++)
        exp_q.push_back('{dx, dy, 0});
  endtask

  task automatic run_search(input int range, input int thresh, input int mode,
                            input bit rnd, input int latency, input string tag);
    bit   got;
    logic prev_busy;
    int   min_sad, best_i;
    sad_mode   = mode;
    rand_ready = rnd;
    lat        = latency;
    load_window(range);
    cfg_range  = MV_W'(range);
    cfg_thresh = SAD_W'(thresh);
    start = 1'b1;
    step();
    start = 1'b0;
    check({tag, "_busy_rise"}, busy, 1);
    check({tag, "_valid_rise"}, cand_valid, 1);
    // A second start mid-search must be ignored.
    cfg_range  = MV_W'(range + 1);
    cfg_thresh = '1;
    start = 1'b1;
    step();
    start = 1'b0;
    got = 1'b0;
    prev_busy = busy;
    for (int i = 0; i < 5000 && !got; i++) begin
      prev_busy = busy;
      step();
      if (done === 1'b1) got = 1'b1;
    end
    check({tag, "_done_seen"}, got, 1);
    if (got) begin
      check({tag, "_busy_before_done"}, prev_busy, 1);
      check({tag, "_busy_fall"}, busy, 0);
      check({tag, "_all_returned"}, n_out, 0);
      if (mode == 3) check({tag, "_early_count_short"}, iss_q.size() < exp_q.size(), 1);
      else           check({tag, "_cand_count"}, iss_q.size(), exp_q.size());
      min_sad = 1 << 30;
      best_i  = 0;
      foreach (iss_q[k]) if (iss_q[k].sad < min_sad) min_sad = iss_q[k].sad;
      for (int k = iss_q.size() - 1; k >= 0; k--) if (iss_q[k].sad == min_sad) best_i = k;
      if (iss_q.size() > 0) begin
        check({tag, "_best_dx"}, best_dx, iss_q[best_i].dx);
        check({tag, "_best_dy"}, best_dy, iss_q[best_i].dy);
        check({tag, "_best_sad"}, best_sad, min_sad);
      end
      step();
      check({tag, "_done_pulse"}, done, 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    start      = 1'b0;
    cfg_range  = '0;
    cfg_thresh = '0;
    cand_ready = 1'b0;
    sad_valid  = 1'b0;
    sad_value  = '0;
    tb_ARESETN = 1'b0;
    repeat (3) step();
    check("rst_cand_valid", cand_valid, 0);
    check("rst_cand_dx", cand_dx, 0);
    check("rst_cand_dy", cand_dy, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_best_dx", best_dx, 0);
    check("rst_best_dy", best_dy, 0);
    check("rst_best_sad", best_sad, 0);
    tb_ARESETN = 1'b1;
    step();

    // R=1, |dx|+|dy|+5, full-rate issue.
    run_search(1, 0, 0, 1'b0, 3, "t1");
    check("t1_issue_span", last_hs_cyc - first_hs_cyc + 1, 9);
    check("t1_sad_const", best_sad, 5);

    // Stray SAD with nothing outstanding; results must hold.
    inject = 1'b1;
    repeat (3) step();
    check("stray_best_sad", best_sad, 5);
    check("stray_best_dx", best_dx, 0);
    check("stray_busy", busy, 0);

    // Tie at SAD 7: first in raster order wins.
    run_search(2, 0, 1, 1'b0, 4, "t2");
    check("t2_best_dx_const", best_dx, 1);
    check("t2_best_dy_const", best_dy, -2);

    // Range clamp 12 -> 8.
    run_search(12, 0, 0, 1'b0, 2, "t3");
    if (iss_q.size() == 289) begin
      check("t3_first_dx", iss_q[0].dx, -8);
      check("t3_first_dy", iss_q[0].dy, -8);
      check("t3_last_dx", iss_q[288].dx, 8);
      check("t3_last_dy", iss_q[288].dy, 8);
    end

    // Random 30% ready, latency 20, random SADs.
    run_search(3, 0, 2, 1'b1, 20, "t4");
    rand_ready = 1'b0;

    // Reset mid-ISSUE, stale returns ignored, then R=0.
    sad_mode   = 0;
    lat        = 6;
    load_window(4);
    cfg_range  = MV_W'(4);
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (12) step();
    tb_ARESETN = 1'b0;
    step();
    n_out     = 0;
    stale_cnt = pend_q.size();
    check("mid_rst_valid", cand_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_best_sad", best_sad, 0);
    check("mid_rst_cand_dx", cand_dx, 0);
    step();
    tb_ARESETN = 1'b1;
    for (int i = 0; i < 100 && pend_q.size() > 0; i++) step();
    repeat (2) step();
    check("post_rst_busy", busy, 0);
    check("post_rst_best_sad", best_sad, 0);
    run_search(0, 0, 4, 1'b0, 2, "t5");
    check("t5_best_sad_const", best_sad, 33);

`ifdef ME_EARLY_TERM_EN
    run_search(3, 10, 3, 1'b0, 3, "t6");
    check("t6_best_sad_le4", best_sad <= 4, 1);
`endif

    repeat (2) step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/me_search_sched.md
# me_search_sched

Search-window scheduler for the motion-estimation match datapath. On a start command it walks every candidate motion vector of a square search window in raster order and issues each offset to the SAD datapath through a valid/ready handshake. It collects the returned SAD values and tracks the minimum, then reports the best vector and SAD with a done pulse. It sits between the AXI4-Lite register slave of the me_match IP (start, range and threshold registers; result and status read-back) and the SAD compute pipeline.

## Interface
- MAX_RANGE, 8, largest search radius supported; offsets span −MAX_RANGE..+MAX_RANGE
- MV_W, 5, signed width of dx/dy; must hold ±MAX_RANGE
- SAD_W, 16, unsigned SAD width
- MAX_OUTSTANDING, 8, maximum issued-but-unreturned candidates

Ports:
- s00_axi_aclk  in  1  clock
- s00_axi_aresetn  in  1  reset; synchronous, active-low
- start  in  1  one-cycle pulse, begins a search
- cfg_range  in  MV_W  search radius R, unsigned, sampled on accepted start
- cfg_thresh  in  SAD_W  early-termination threshold, sampled on accepted start
- cand_valid  out  1  candidate offset valid
- cand_ready  in  1  datapath accepts candidate
- cand_dx, cand_dy  out  MV_W  signed candidate offset
- sad_valid  in  1  SAD result valid; no backpressure; results return in issue order
- sad_value  in  SAD_W  SAD of oldest outstanding candidate
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse when the search completes
- best_dx, best_dy  out  MV_W  vector of the minimum SAD
- best_sad  out  SAD_W  minimum SAD

## Operation
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE: start → latch R = min(cfg_range, MAX_RANGE) and the threshold; clear best_sad to all-ones; go to ISSUE.
- ISSUE: present (dx,dy) with dy outer loop and dx inner loop, both from −R to +R. Advance on cand_valid & cand_ready. Stall (cand_valid low) while outstanding == MAX_OUTSTANDING. After the last candidate (+R,+R) is accepted, go to DRAIN.
- DRAIN: cand_valid low. When outstanding reaches 0, go to DONE.
- DONE: pulse done for one cycle, then return to IDLE.
- Outstanding counter: +1 on handshake, −1 on sad_valid, net 0 when both happen in the same cycle.
- Result tracking: a FIFO of issued offsets, depth MAX_OUTSTANDING. On sad_valid, pop the offset and update the best values if sad_value < best_sad. The comparison is strict, so the first minimum in raster order wins a tie.
- R = 0 searches a single candidate (0,0).
- start while busy is ignored. sad_valid with outstanding == 0 is ignored.
- best_dx, best_dy and best_sad update live during the search and hold after done until the next accepted start.

## Timing
- Reset values: cand_valid 0, cand_dx/dy 0, busy 0, done 0, best_dx/dy 0, best_sad 0; FSM in IDLE; counters and FIFO empty.
- cand_valid rises the cycle after the accepted start. busy rises in that same cycle.
- With cand_ready held high: one candidate per cycle, (2R+1)² cycles of issue.
- done is asserted the cycle after the FSM reaches outstanding == 0. busy falls in the same cycle done rises.
- cand_dx and cand_dy are registered and stay stable while cand_valid & !cand_ready.
- Reset during a search: immediate return to IDLE with reset values; late sad_valid is then ignored.

## Configuration
- ME_EARLY_TERM_EN defined: in ISSUE, a sad_valid with sad_value < cfg_thresh latched → stop issuing and go to DRAIN. Drained results still update the best values.
- ME_EARLY_TERM_EN undefined: cfg_thresh is unused and the full window is always searched.

## Structure
- me_match_pkg holds the FSM state enum, the MV_W/SAD_W defaults, and the SAD_MAX all-ones constant.
- Sub-module me_best_tracker holds the offset FIFO, strict-less compare and best registers. The scheduler keeps the FSM, raster counters and outstanding counter.

## Test plan
- R=1, cand_ready always high, datapath latency 3, SAD = |dx|+|dy|+5 → 9 candidates, done with best (0,0), best_sad 5.
- R=2, all SADs 100 except (+1,−2)=7 and (+2,+2)=7 → best (+1,−2), best_sad 7 (first in raster order wins the tie).
- cfg_range=12 with MAX_RANGE 8 → clamps to 8; 289 candidates issued; first offset (−8,−8), last (+8,+8).
- Random cand_ready at 30% and datapath latency 20 → outstanding never exceeds 8; offsets stable under stall; results match the model.
- Reset asserted mid-ISSUE, then start with R=0 → one candidate (0,0); done follows its sad_valid.
- ME_EARLY_TERM_EN, cfg_thresh=10, R=3, the third candidate returns SAD 4 → issue stops; done after drain; best_sad ≤ 4.
